// File: rtl/crc_frame_checker_if.sv
// crc_frame_checker_if
//   Bundles the frame input, host handshake and result signals of
//   crc_frame_checker. The master modport is the host/deserialiser side,
//   the slave modport is the checker.
//   Host -> checker : taps, init_value, start, bit_valid, bit_data, bit_last, ack
//   Checker -> host : busy, done, crc_ok, short_err, residue, crc_rx, bit_count
interface crc_frame_checker_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic [N-1:0]     taps;
  logic [N-1:0]     init_value;
  logic             start;
  logic             bit_valid;
  logic             bit_data;
  logic             bit_last;
  logic             ack;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             short_err;
  logic [N-1:0]     residue;
  logic [N-1:0]     crc_rx;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output taps, init_value, start, bit_valid, bit_data, bit_last, ack,
    input  busy, done, crc_ok, short_err, residue, crc_rx, bit_count
  );

  modport slave (
    input  taps, init_value, start, bit_valid, bit_data, bit_last, ack,
    output busy, done, crc_ok, short_err, residue, crc_rx, bit_count
  );
endinterface

// File: rtl/crc_frame_checker.sv
// crc_frame_checker
//   Receive-side serial CRC checker. Runs a Galois LFSR over the payload
//   and the trailing N CRC bits (all MSB-first); a zero residue after the
//   last bit means the frame is intact. The result is held in RESULT until
//   the host acks it or starts a new frame.
//   Ports:
//     clk, rst  : rising-edge clock, synchronous active-high reset
//     bus       : crc_frame_checker_if.slave (frame input, handshake, results)
//     err_count : [7:0] saturating count of failed frames, present only when
//                 CRC_CHK_ERR_COUNT_EN is defined
//   Parameters: N (CRC width, >= 2), CNT_W (bit counter width, saturating).
module crc_frame_checker #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CRC_CHK_ERR_COUNT_EN
  output logic [7:0]           err_count,
`endif
  crc_frame_checker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

  localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(N + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_preset;
  logic             w_step;
  logic             w_finish;

  logic [N-1:0]     r_residue;
  logic [N-1:0]     r_crc_rx;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_crc_ok;
  logic             r_short_err;

  logic             w_fb;
  logic [N-1:0]     w_shift;
  logic [N-1:0]     w_residue_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_short;
  logic             w_ok;

  // Forcing taps[0] high before the XOR is equivalent to replacing bit 0
  // with 1, since the shifted value always has bit 0 clear.
  assign w_fb           = r_residue[N-1] ^ bus.bit_data;
  assign w_shift        = r_residue << 1;
  assign w_residue_next = w_fb ? (w_shift ^ (bus.taps | N'(1))) : w_shift;
  assign w_count_next   = (&r_bit_count) ? r_bit_count : r_bit_count + 1'b1;
  assign w_short        = (w_count_next < MIN_BITS);
  assign w_ok           = (w_residue_next == '0) && !w_short;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_preset     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_preset     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (bus.start) begin
          w_preset = 1'b1;
        end else if (bus.bit_valid) begin
          w_step = 1'b1;
          if (bus.bit_last) begin
            w_finish     = 1'b1;
            w_state_next = RESULT;
          end
        end
      end
      RESULT: begin
        if (bus.start) begin
          w_preset     = 1'b1;
          w_state_next = RUN;
        end else if (bus.ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_residue   <= '0;
      r_crc_rx    <= '0;
      r_bit_count <= '0;
      r_crc_ok    <= 1'b0;
      r_short_err <= 1'b0;
    end else if (w_preset) begin
      r_residue   <= bus.init_value;
      r_crc_rx    <= '0;
      r_bit_count <= '0;
    end else if (w_step) begin
      r_residue   <= w_residue_next;
      r_crc_rx    <= {r_crc_rx[N-2:0], bus.bit_data};
      r_bit_count <= w_count_next;
      if (w_finish) begin
        r_crc_ok    <= w_ok;
        r_short_err <= w_short;
      end
    end
  end

`ifdef CRC_CHK_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_finish && !w_ok && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == RESULT);
  assign bus.crc_ok    = r_crc_ok;
  assign bus.short_err = r_short_err;
  assign bus.residue   = r_residue;
  assign bus.crc_rx    = r_crc_rx;
  assign bus.bit_count = r_bit_count;

endmodule
